// File: rtl/dealer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dealer_pkg
//  Purpose  : Shared constants and state encoding for the card dealer.
//             Deck geometry (52 cards, 13 ranks), face-card point value and
//             the IDLE / PROBE / DONE dealer state codes.
//  Revision : 1.0  initial release
// ============================================================================
package dealer_pkg;

    // Deck geometry; sized to the 6-bit card index so comparisons stay
    // width-matched against idx registers.
    localparam logic [5:0] DECK_SIZE   = 6'd52;
    localparam logic [5:0] RANKS       = 6'd13;
    localparam logic [5:0] LAST_IDX    = DECK_SIZE - 6'd1;
    localparam logic [3:0] FACE_POINTS = 4'd10;

    // Dealer state encoding
    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/card_decode.sv
`default_nettype none
// ============================================================================
//  Module   : card_decode
//  Purpose  : Combinational card decoder. Maps a deck index 0..51 to its
//             rank (1..13), blackjack points (rank, or 10 for J/Q/K) and
//             suit (index / 13).
//  Ports    : i_idx    [5:0]  deck index, 0..51
//             o_rank   [3:0]  rank 1..13 (1 = Ace, 11..13 = J,Q,K)
//             o_points [3:0]  blackjack point value
//             o_suit   [1:0]  suit 0..3
//  Revision : 1.0  initial release
// ============================================================================
module card_decode
    import dealer_pkg::*;
(
    input  logic [5:0] i_idx,
    output logic [3:0] o_rank,
    output logic [3:0] o_points,
    output logic [1:0] o_suit
);

    localparam logic [5:0] c_SUIT1_BASE = RANKS;
    localparam logic [5:0] c_SUIT2_BASE = RANKS + RANKS;
    localparam logic [5:0] c_SUIT3_BASE = c_SUIT2_BASE + RANKS;

    logic [5:0] w_rem;

    // Division by 13 over a 0..51 range reduces to three threshold compares.
    always_comb begin
        o_suit = 2'd0;
        w_rem  = i_idx;
        if (i_idx >= c_SUIT3_BASE) begin
            o_suit = 2'd3;
            w_rem  = i_idx - c_SUIT3_BASE;
        end else if (i_idx >= c_SUIT2_BASE) begin
            o_suit = 2'd2;
            w_rem  = i_idx - c_SUIT2_BASE;
        end else if (i_idx >= c_SUIT1_BASE) begin
            o_suit = 2'd1;
            w_rem  = i_idx - c_SUIT1_BASE;
        end
        // Remainder is 0..12, so the low nibble carries it exactly.
        o_rank   = 4'(w_rem) + 4'd1;
        o_points = (o_rank > FACE_POINTS) ? FACE_POINTS : o_rank;
    end

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : card_dealer
//  Purpose  : Deals one card per draw request from a single 52-card deck
//             with no repeats. The free-running seed counter is sampled on
//             an accepted draw, folded to 0..51, and collisions with already
//             dealt cards are resolved by linear probing (one mask bit per
//             cycle, wrapping 51 -> 0).
//  Ports    : clk_50M       system clock
//             i_Reset       synchronous active-high reset
//             i_Seed        counter value, only bits [5:0] used
//             i_Draw        draw request, honoured in IDLE only
//             i_Shuffle     return all cards to the deck (aborts a draw)
//             o_Card        rank 1..13
//             o_Value       blackjack points
//             o_Valid       one-cycle pulse when a new card is presented
//             o_Busy        high while probing
//             o_Empty       high when no cards remain
//             o_CardsLeft   cards remaining, 0..52
//             o_Suit        suit 0..3 (only with CARD_DEALER_SUIT_EN)
//  Options  : `define CARD_DEALER_SUIT_EN to add the o_Suit output.
//  Revision : 1.0  initial release
// ============================================================================
module card_dealer
    import dealer_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Value,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Empty,
`ifdef CARD_DEALER_SUIT_EN
    output logic [1:0]       o_Suit,
`endif
    output logic [5:0]       o_CardsLeft
);

    logic [STATE_W-1:0] r_state_q;
    logic [STATE_W-1:0] w_state_d;
    logic [5:0]         r_idx_q;
    logic [51:0]        r_mask_q;
    logic [3:0]         r_card_q;
    logic [3:0]         r_value_q;
    logic [5:0]         r_left_q;
    logic               r_empty_q;

    logic [5:0]         w_seed_lo;
    logic [5:0]         w_fold_idx;
    logic [5:0]         w_next_idx;
    logic               w_hit;
    logic               w_accept;
    logic [3:0]         w_dec_rank;
    logic [3:0]         w_dec_points;
    logic [1:0]         w_dec_suit;

    // Upper seed bits carry no information for the deal.
    generate
        if (WIDTH > 6) begin : g_seed_hi
            logic w_seed_hi_unused;
            assign w_seed_hi_unused = ^i_Seed[WIDTH-1:6];
        end
    endgenerate

    // Fold 0..63 onto 0..51 with a single conditional subtract.
    assign w_seed_lo  = i_Seed[5:0];
    assign w_fold_idx = (w_seed_lo >= DECK_SIZE) ? (w_seed_lo - DECK_SIZE) : w_seed_lo;

    assign w_hit      = ~r_mask_q[r_idx_q];
    assign w_next_idx = (r_idx_q == LAST_IDX) ? 6'd0 : (r_idx_q + 6'd1);
    // Entry requires a card to remain, which bounds the probe to 52 cycles.
    assign w_accept   = i_Draw & ~r_empty_q;

    card_decode u_card_decode (
        .i_idx    (r_idx_q),
        .o_rank   (w_dec_rank),
        .o_points (w_dec_points),
        .o_suit   (w_dec_suit)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; shuffle overrides any in-flight draw.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        if (i_Shuffle) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE:  if (w_accept) w_state_d = ST_PROBE;
                ST_PROBE: if (w_hit)    w_state_d = ST_DONE;
                ST_DONE:                w_state_d = ST_IDLE;
                default:                w_state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        o_Valid = (r_state_q == ST_DONE);
        o_Busy  = (r_state_q == ST_PROBE);
    end

    // ------------------------------------------------------------------
    // Datapath: probe index, used-mask, dealt card and remaining count
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            r_idx_q   <= 6'd0;
            r_mask_q  <= '0;
            r_card_q  <= 4'd0;
            r_value_q <= 4'd0;
            r_left_q  <= DECK_SIZE;
            r_empty_q <= 1'b0;
        end else if (i_Shuffle) begin
            // Card/value outputs deliberately keep the last dealt card.
            r_mask_q  <= '0;
            r_left_q  <= DECK_SIZE;
            r_empty_q <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx_q <= w_fold_idx;
                    end
                end
                ST_PROBE: begin
                    if (w_hit) begin
                        r_mask_q[r_idx_q] <= 1'b1;
                        r_card_q          <= w_dec_rank;
                        r_value_q         <= w_dec_points;
                        r_left_q          <= r_left_q - 6'd1;
                        r_empty_q         <= (r_left_q == 6'd1);
                    end else begin
                        r_idx_q <= w_next_idx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CARD_DEALER_SUIT_EN
    logic [1:0] r_suit_q;

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            r_suit_q <= 2'd0;
        end else if (!i_Shuffle && (r_state_q == ST_PROBE) && w_hit) begin
            r_suit_q <= w_dec_suit;
        end
    end

    assign o_Suit = r_suit_q;
`else
    logic w_suit_unused;
    assign w_suit_unused = ^w_dec_suit;
`endif

    assign o_Card      = r_card_q;
    assign o_Value     = r_value_q;
    assign o_CardsLeft = r_left_q;
    assign o_Empty     = r_empty_q;

endmodule
`default_nettype wire
